// File: rtl/catch_ctrl_pkg.sv
// catch_ctrl_pkg: state encoding and default geometry shared by the catch buffer sequencer and arbiter.
package catch_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, CATCH, SERVE} state_t;
   localparam int DEF_CATCH_NUM = 100;
   localparam int DEF_CATCH_NUM_WIDTH = $clog2(DEF_CATCH_NUM);
   localparam int DEF_NREQ = 3;
   function automatic int ptr_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or above rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   winner
);
   always_comb begin
      winner = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req[(int'(rr_ptr) + k) % NREQ]) winner = PW'((int'(rr_ptr) + k) % NREQ);
      gnt = (|req) ? NREQ'(1) << winner : '0;
   end
endmodule

// File: rtl/catch_buffer_arbiter.sv
// catch_buffer_arbiter: clears and fills the catch buffer with CATCH_NUM samples,
// then shares its single read port among NREQ requesters round-robin.
module catch_buffer_arbiter
   import catch_ctrl_pkg::*;
#(
   parameter int CATCH_NUM = DEF_CATCH_NUM,
   parameter int CATCH_NUM_WIDTH = $clog2(CATCH_NUM),
   parameter int N = 64,
   parameter int Q = 15,
   parameter int NREQ = DEF_NREQ
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   input  logic                            src_valid,
   input  logic [N-1:0]                    src_data,
   output logic                            src_ready,
   output logic                            buf_rst,
   output logic                            buf_catch_en,
   output logic [N-1:0]                    buf_catch_data,
   output logic [CATCH_NUM_WIDTH-1:0]      buf_index,
   input  logic [N-1:0]                    buf_fixed_point,
   input  logic [NREQ-1:0]                 req,
   input  logic [NREQ*CATCH_NUM_WIDTH-1:0] req_index,
   output logic [NREQ-1:0]                 gnt,
   output logic [NREQ-1:0]                 rd_valid,
   output logic [N-1:0]                    rd_data,
   output logic                            rd_err
);
   localparam int W = CATCH_NUM_WIDTH;
   localparam int PW = ptr_width(NREQ);
   localparam logic [W-1:0] LAST = W'(CATCH_NUM - 1);

   // Q only tells consumers how to read the samples; nothing here does arithmetic on them.
   if (Q >= N) begin : g_q_exceeds_sample
   end

   state_t          state;
   logic [W-1:0]    count;
   logic [W-1:0]    sel_idx;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   winner;
   logic [NREQ-1:0] arb_gnt;
   logic            granted;
   logic            oor;
   logic            last_beat;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (arb_gnt),
      .winner (winner)
   );

   assign busy           = state == CLEAR || state == CATCH;
   assign buf_rst        = state == CLEAR;
   assign src_ready      = state == CATCH;
   assign buf_catch_en   = src_ready && src_valid;
   assign buf_catch_data = src_data;
   assign last_beat      = buf_catch_en && count == LAST;
   assign done           = last_beat;
   // A restart request in SERVE suppresses new grants so no read straddles the clear.
   assign gnt            = state == SERVE && !start ? arb_gnt : '0;
   assign granted        = |gnt;
   assign sel_idx        = req_index[int'(winner)*W +: W];
   assign oor            = sel_idx > LAST;
   assign buf_index      = granted && !oor ? sel_idx : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         count    <= '0;
         rr_ptr   <= '0;
         rd_valid <= '0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= gnt;
         rd_err   <= granted && oor;
         if (granted) begin
            rd_data <= oor ? '0 : buf_fixed_point;
            rr_ptr  <= winner == PW'(NREQ - 1) ? '0 : winner + 1'b1;
         end
         if (state == CLEAR) count <= '0;
         else if (buf_catch_en) count <= count + 1'b1;
         case (state)
            IDLE:    if (start) state <= CLEAR;
            CLEAR:   state <= CATCH;
            CATCH:   if (last_beat) state <= SERVE;
            default: if (start) state <= CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_catch_buffer_arbiter.sv
// tb_catch_buffer_arbiter: table-driven reads with a read-return scoreboard, plus capture,
// restart and mid-capture reset sequences against a behavioural catch buffer.
module tb_catch_buffer_arbiter;
   localparam int CN = 100;
   localparam int W = 7;
   localparam int N = 64;
   localparam int NR = 3;

   typedef struct {
      logic [NR-1:0] req;
      logic [W-1:0]  i0, i1, i2;
      logic [NR-1:0] gnt;
      logic [N-1:0]  data;
      logic          err;
   } vec_t;

   typedef struct {
      logic [NR-1:0] v;
      logic [N-1:0]  d;
      logic          e;
   } rd_t;

   logic            clk, rst, start, src_valid;
   logic [N-1:0]    src_data;
   logic            busy, done, src_ready, buf_rst, buf_catch_en;
   logic [N-1:0]    buf_catch_data, buf_fixed_point, rd_data;
   logic [W-1:0]    buf_index;
   logic [NR-1:0]   req, gnt, rd_valid;
   logic [NR*W-1:0] req_index;
   logic            rd_err;

   logic [N-1:0] mem [CN];
   int           wptr;
   int           n_vec, n_err;
   rd_t          sb[$];
   vec_t         tab[$];

   catch_buffer_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .src_valid       (src_valid),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .buf_rst         (buf_rst),
      .buf_catch_en    (buf_catch_en),
      .buf_catch_data  (buf_catch_data),
      .buf_index       (buf_index),
      .buf_fixed_point (buf_fixed_point),
      .req             (req),
      .req_index       (req_index),
      .gnt             (gnt),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .rd_err          (rd_err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Behavioural catch buffer: sync clear, write pointer, combinational read.
   always @(posedge clk) begin
      if (buf_rst) wptr <= 0;
      else if (buf_catch_en && wptr < CN) begin
         mem[wptr] <= buf_catch_data;
         wptr <= wptr + 1;
      end
   end
   assign buf_fixed_point = buf_index < W'(CN) ? mem[buf_index] : '0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_rd();
      rd_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("rd_valid", rd_valid, x.v);
         chk("rd_data", rd_data, x.d);
         chk("rd_err", rd_err, x.e);
      end else begin
         chk("rd_valid_idle", rd_valid, 0);
         chk("rd_err_idle", rd_err, 0);
      end
   endtask

   task automatic step(input vec_t t);
      logic [W-1:0] bi;
      check_rd();
      req = t.req;
      req_index = {t.i2, t.i1, t.i0};
      #1;
      chk("gnt", gnt, t.gnt);
      bi = t.gnt[0] ? t.i0 : t.gnt[1] ? t.i1 : t.gnt[2] ? t.i2 : '0;
      if (t.err) bi = '0;
      chk("buf_index", buf_index, bi);
      if (t.gnt != 0) sb.push_back('{t.gnt, t.data, t.err});
      @(negedge clk);
   endtask

   task automatic capture(input logic [N-1:0] base);
      int beats = 0, rsts = 0, dones = 0, cyc = 0;
      logic done_last = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      while (beats < CN && cyc < 400) begin
         src_valid = (cyc % 3) != 2;
         src_data = base + N'(beats);
         #1;
         rsts += int'(buf_rst);
         dones += int'(done);
         if (buf_catch_en) begin
            beats++;
            if (beats == CN) done_last = done;
         end
         cyc++;
         @(negedge clk);
      end
      src_valid = 0;
      #1;
      chk("catch_beats", N'(beats), N'(CN));
      chk("buf_rst_cycles", N'(rsts), 1);
      chk("done_pulses", N'(dones), 1);
      chk("done_on_last_beat", N'(done_last), 1);
      chk("src_ready_after", N'(src_ready), 0);
      chk("busy_after", N'(busy), 0);
      chk("buf_writes", N'(wptr), N'(CN));
      @(negedge clk);
   endtask

   initial begin
      int beats, cyc;
      n_vec = 0;
      n_err = 0;
      rst = 0;
      start = 0;
      src_valid = 0;
      src_data = '0;
      req = '0;
      req_index = '0;
      tab.push_back('{3'b001, 7'd42, 7'd0, 7'd0, 3'b001, 64'd42, 1'b0});
      tab.push_back('{3'b010, 7'd0, 7'd100, 7'd0, 3'b010, 64'd0, 1'b1});
      tab.push_back('{3'b100, 7'd0, 7'd0, 7'd7, 3'b100, 64'd7, 1'b0});
      for (int i = 0; i < 6; i++)
         tab.push_back('{3'b111, 7'd1, 7'd2, 7'd3, NR'(1) << (i % 3), 64'(i % 3 + 1), 1'b0});
      tab.push_back('{3'b000, 7'd0, 7'd0, 7'd0, 3'b000, 64'd0, 1'b0});
      tab.push_back('{3'b110, 7'd0, 7'd10, 7'd20, 3'b010, 64'd10, 1'b0});
      tab.push_back('{3'b101, 7'd5, 7'd0, 7'd20, 3'b100, 64'd20, 1'b0});
      tab.push_back('{3'b011, 7'd5, 7'd30, 7'd0, 3'b001, 64'd5, 1'b0});
      tab.push_back('{3'b010, 7'd0, 7'd30, 7'd0, 3'b010, 64'd30, 1'b0});
      tab.push_back('{3'b101, 7'd127, 7'd0, 7'd99, 3'b100, 64'd99, 1'b0});
      tab.push_back('{3'b001, 7'd127, 7'd0, 7'd0, 3'b001, 64'd0, 1'b1});
      tab.push_back('{3'b000, 7'd0, 7'd0, 7'd0, 3'b000, 64'd0, 1'b0});

      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", N'(busy), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", N'(rd_valid), 0);
      rst = 1;
      req = 3'b111;
      req_index = {7'd3, 7'd2, 7'd1};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("idle_gnt", N'(gnt), 0);
         chk("idle_outs", N'({busy, done, src_ready, buf_rst, buf_catch_en, rd_valid, rd_err}), 0);
         chk("idle_buf_index", N'(buf_index), 0);
      end
      req = '0;
      @(negedge clk);

      capture(64'd0);
      foreach (tab[i]) step(tab[i]);

      // Restart while a read is in flight.
      step('{3'b010, 7'd0, 7'd42, 7'd0, 3'b010, 64'd42, 1'b0});
      check_rd();
      start = 1;
      req = 3'b001;
      req_index = {7'd0, 7'd0, 7'd9};
      #1;
      chk("restart_gnt", N'(gnt), 0);
      @(negedge clk);
      start = 0;
      req = '0;
      #1;
      chk("restart_rd_valid", N'(rd_valid), 0);
      chk("restart_clear", N'(buf_rst), 1);
      chk("restart_busy", N'(busy), 1);
      @(negedge clk);
      #1;
      chk("restart_catch", N'(src_ready), 1);

      // Reset at sample 50 of the new capture.
      beats = 0;
      cyc = 0;
      while (beats < 50 && cyc < 200) begin
         src_valid = 1;
         src_data = N'(500 + beats);
         #1;
         if (buf_catch_en) beats++;
         cyc++;
         @(negedge clk);
      end
      chk("partial_beats", N'(beats), 50);
      #2 rst = 0;
      #1;
      chk("midrst_outs", N'({busy, done, src_ready, buf_rst, buf_catch_en, gnt, rd_valid, rd_err}), 0);
      chk("midrst_rd_data", rd_data, 0);
      src_valid = 0;
      @(negedge clk);
      rst = 1;
      capture(64'd1000);
      step('{3'b001, 7'd0, 7'd0, 7'd0, 3'b001, 64'd1000, 1'b0});
      step('{3'b010, 7'd0, 7'd50, 7'd0, 3'b010, 64'd1050, 1'b0});
      step('{3'b100, 7'd0, 7'd0, 7'd99, 3'b100, 64'd1099, 1'b0});
      step('{3'b000, 7'd0, 7'd0, 7'd0, 3'b000, 64'd0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/catch_buffer_arbiter.md
Name: catch_buffer_arbiter

Overview:
- Sequencer and read-port arbiter for the E1 fixed-point catch buffer.
- Clears the buffer's write pointer, then admits exactly CATCH_NUM samples from an upstream valid/ready source into the buffer.
- After capture, shares the buffer's single combinational read port among NREQ requesters using round-robin, one read per cycle.
- Sits between the fixed-point producer, the catch buffer and downstream consumers.

Parameters:
- CATCH_NUM, 100, number of samples per capture; equals the buffer depth.
- CATCH_NUM_WIDTH, $clog2(CATCH_NUM), width of index fields.
- N, 64, sample width in bits.
- Q, 15, fractional bits. Carried through only; there is no arithmetic on data.
- NREQ, 3, number of read requesters (at least 1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a capture.
- busy  out  1  high in CLEAR and CATCH.
- done  out  1  one-cycle pulse on the CATCH->SERVE transition.
- src_valid  in  1  upstream sample valid.
- src_data  in  N  upstream sample.
- src_ready  out  1  high only in CATCH.
- buf_rst  out  1  synchronous, active-high clear to the buffer.
- buf_catch_en  out  1  buffer write strobe.
- buf_catch_data  out  N  buffer write data; equals src_data.
- buf_index  out  CATCH_NUM_WIDTH  buffer read address.
- buf_fixed_point  in  N  buffer read data; combinational from buf_index.
- req  in  NREQ  per-requester read request.
- req_index  in  NREQ*CATCH_NUM_WIDTH  packed read addresses; requester i uses slice i.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the request.
- rd_valid  out  NREQ  one-hot, registered; asserts one cycle after gnt.
- rd_data  out  N  registered read data.
- rd_err  out  1  registered; flags an out-of-range address for the read returned in this cycle.

Behaviour:
- Reset: asynchronous on rst=0.
  - State=IDLE; count=0; rr_ptr=0.
  - busy, done, src_ready, buf_catch_en, buf_rst, gnt, rd_valid and rd_err are 0.
  - rd_data=0.
- States: IDLE, CLEAR, CATCH, SERVE.
- IDLE:
  - start -> CLEAR.
  - req is ignored and gnt=0.
- CLEAR (exactly 1 cycle):
  - buf_rst=1, count<=0, then -> CATCH.
  - start is ignored.
- CATCH:
  - src_ready=1 and buf_catch_en=src_valid.
  - Each accepted beat increments count.
  - The accepted beat with count==CATCH_NUM-1 -> SERVE, and done pulses in that same transition cycle.
  - No grants are issued; start is ignored.
  - src_valid low stalls the capture indefinitely with no timeout.
- SERVE:
  - Arbitration: the winner is the first i with req[i]=1, searching from rr_ptr upward modulo NREQ.
  - On a grant:
    - gnt[winner]=1 and buf_index=req_index[winner];
    - rr_ptr<=(winner+1) mod NREQ;
    - next cycle: rd_valid[winner]=1 and rd_data=buf_fixed_point as sampled.
  - With no request, gnt=0 and rr_ptr holds.
  - Read throughput is 1 per cycle and latency is 1 cycle.
  - Requesters hold req and req_index stable until they see gnt. A requester may re-request immediately after its grant.
- Out-of-range address (req_index >= CATCH_NUM):
  - The read is still granted.
  - Next cycle: rd_data=0 and rd_err=1.
  - buf_index is driven with 0.
- start in SERVE -> CLEAR.
  - No new grants are issued in that cycle.
  - A read granted in the previous cycle still returns its rd_valid.
- Outside SERVE, buf_index=0.
- Every registered output with no pending update returns to 0 the following cycle. rd_data holds its last value.
- Reset mid-CATCH: the FSM returns to IDLE at once. Buffer contents are undefined until the next start.

Decomposition:
- Package catch_ctrl_pkg:
  - state enum (IDLE, CLEAR, CATCH, SERVE);
  - localparam widths derived from CATCH_NUM.
- Sub-module rr_arbiter (NREQ):
  - inputs: req, rr_ptr;
  - outputs: one-hot gnt and the encoded winner;
  - purely combinational.
- The FSM, counter, pointer and read-return registers live in the top module.

Test Plan:
- Reset/idle: hold rst=0, then release with start=0 and req=3'b111 -> all outputs stay 0, gnt=0, state IDLE.
- Capture with stalls: pulse start; drive src_data=i for i=0..99 with src_valid low every 3rd cycle.
  - buf_rst is high for exactly 1 cycle.
  - buf_catch_en fires exactly 100 times and src_ready drops after beat 99.
  - done pulses once.
- Single read: in SERVE, req=3'b001 with index 42 -> gnt=3'b001 in the same cycle; next cycle rd_valid=3'b001 and rd_data=42.
- Round-robin fairness: req=3'b111 held 6 cycles, with indices 1/2/3 and rr_ptr=0.
  - Grant order is 0,1,2,0,1,2.
  - rd_data is 1,2,3,1,2,3, each lagging its grant by one cycle.
- Out of range: req=3'b010 with index 100 -> buf_index=0; next cycle rd_valid=3'b010, rd_data=0, rd_err=1.
- Restart and reset:
  - start in SERVE while a read is in flight -> that rd_valid still appears, then CLEAR, then CATCH.
  - rst=0 at sample 50 of a capture -> immediate IDLE with all outputs 0; a new start captures 100 fresh samples from index 0.
